// File: rtl/decode_issue_if.sv
// Handshake and data bundle between fetch/decode, the decode_issue_stage and execute.
// The slave modport is the stage's view; master is the surrounding pipeline's view.
interface decode_issue_if #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int CTRL_W   = 26,
    parameter int WB_PORTS = 2
);
    localparam int AW = $clog2(NREGS);

    logic                     in_valid;
    logic                     in_ready;
    logic [XLEN-1:0]          in_pc;
    logic [XLEN-1:0]          in_pc_plus;
    logic [XLEN-1:0]          in_pred_pc;
    logic                     in_pred_taken;
    logic [AW-1:0]            in_rs1;
    logic [AW-1:0]            in_rs2;
    logic [AW-1:0]            in_rd;
    logic                     in_rd_we;
    logic                     in_use_imm;
    logic [XLEN-1:0]          in_imm;
    logic [CTRL_W-1:0]        in_ctrl;
    logic                     flush;
    logic [WB_PORTS-1:0]      wb_we;
    logic [WB_PORTS*AW-1:0]   wb_addr;
    logic [WB_PORTS*XLEN-1:0] wb_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          out_data_a;
    logic [XLEN-1:0]          out_data_b;
    logic [XLEN-1:0]          out_store_data;
    logic [XLEN-1:0]          out_pc;
    logic [XLEN-1:0]          out_pc_plus;
    logic [XLEN-1:0]          out_pred_pc;
    logic                     out_pred_taken;
    logic [AW-1:0]            out_rd;
    logic                     out_rd_we;
    logic [CTRL_W-1:0]        out_ctrl;

    modport slave (
        input  in_valid, in_pc, in_pc_plus, in_pred_pc, in_pred_taken,
               in_rs1, in_rs2, in_rd, in_rd_we, in_use_imm, in_imm, in_ctrl,
               flush, wb_we, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_data_a, out_data_b, out_store_data,
               out_pc, out_pc_plus, out_pred_pc, out_pred_taken, out_rd, out_rd_we, out_ctrl
    );

    modport master (
        output in_valid, in_pc, in_pc_plus, in_pred_pc, in_pred_taken,
               in_rs1, in_rs2, in_rd, in_rd_we, in_use_imm, in_imm, in_ctrl,
               flush, wb_we, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_data_a, out_data_b, out_store_data,
               out_pc, out_pc_plus, out_pred_pc, out_pred_taken, out_rd, out_rd_we, out_ctrl
    );
endinterface

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: multi-port regfile with WB bypass, operand select and ID/EX register.
// Define DECODE_ISSUE_PERF_EN to add saturating perf_issued/perf_stall/perf_flush counters.
module decode_issue_stage #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int CTRL_W   = 26,
    parameter int WB_PORTS = 2
) (
    input  logic        clk,
    input  logic        reset,
    decode_issue_if.slave bus
`ifdef DECODE_ISSUE_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);
    localparam int AW = $clog2(NREGS);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus;
        logic [XLEN-1:0]   pred_pc;
        logic              pred_taken;
        logic [AW-1:0]     rd;
        logic              rd_we;
        logic [XLEN-1:0]   data_a;
        logic [XLEN-1:0]   data_b;
        logic [XLEN-1:0]   store_data;
        logic [CTRL_W-1:0] ctrl;
        logic [AW-1:0]     rs1;
        logic [AW-1:0]     rs2;
        logic              use_imm;
    } stage_t;

    logic [XLEN-1:0] rf_reg [NREGS];
    logic [AW-1:0]   wb_addr_w [WB_PORTS];
    logic [XLEN-1:0] wb_data_w [WB_PORTS];

    stage_t          stage_reg;
    stage_t          issue_next;
    logic            in_ready_w;
    logic            fire_w;
    logic [XLEN-1:0] rs1_val_w, rs2_val_w;
    logic            snoop_a_hit_w, snoop_b_hit_w;
    logic [XLEN-1:0] snoop_a_val_w, snoop_b_val_w;

    generate
        for (genvar gi = 0; gi < WB_PORTS; gi++) begin : g_wb_unpack
            assign wb_addr_w[gi] = bus.wb_addr[gi*AW +: AW];
            assign wb_data_w[gi] = bus.wb_data[gi*XLEN +: XLEN];
        end
    endgenerate

    assign in_ready_w   = !stage_reg.valid || bus.out_ready;
    assign fire_w       = bus.in_valid && in_ready_w;
    assign bus.in_ready = in_ready_w;

    // Later ports overwrite earlier ones, so the highest-index matching port wins
    // both for new reads and for snooping operands of a held instruction.
    always_comb begin
        rs1_val_w     = (bus.in_rs1 == '0) ? '0 : rf_reg[bus.in_rs1];
        rs2_val_w     = (bus.in_rs2 == '0) ? '0 : rf_reg[bus.in_rs2];
        snoop_a_hit_w = 1'b0;
        snoop_b_hit_w = 1'b0;
        snoop_a_val_w = '0;
        snoop_b_val_w = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (bus.wb_we[p] && wb_addr_w[p] != '0) begin
                if (wb_addr_w[p] == bus.in_rs1) rs1_val_w = wb_data_w[p];
                if (wb_addr_w[p] == bus.in_rs2) rs2_val_w = wb_data_w[p];
                if (wb_addr_w[p] == stage_reg.rs1) begin
                    snoop_a_hit_w = 1'b1;
                    snoop_a_val_w = wb_data_w[p];
                end
                if (wb_addr_w[p] == stage_reg.rs2) begin
                    snoop_b_hit_w = 1'b1;
                    snoop_b_val_w = wb_data_w[p];
                end
            end
        end
    end

    always_comb begin
        issue_next            = '0;
        issue_next.valid      = 1'b1;
        issue_next.pc         = bus.in_pc;
        issue_next.pc_plus    = bus.in_pc_plus;
        issue_next.pred_pc    = bus.in_pred_pc;
        issue_next.pred_taken = bus.in_pred_taken;
        issue_next.rd         = bus.in_rd;
        issue_next.rd_we      = bus.in_rd_we;
        issue_next.data_a     = rs1_val_w;
        issue_next.data_b     = bus.in_use_imm ? bus.in_imm : rs2_val_w;
        issue_next.store_data = rs2_val_w;
        issue_next.ctrl       = bus.in_ctrl;
        issue_next.rs1        = bus.in_rs1;
        issue_next.rs2        = bus.in_rs2;
        issue_next.use_imm    = bus.in_use_imm;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) rf_reg[r] <= '0;
        end else begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (bus.wb_we[p] && wb_addr_w[p] != '0) rf_reg[wb_addr_w[p]] <= wb_data_w[p];
            end
        end
    end

    // Drain and flush both clear the payload so execute sees an all-zero NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_reg <= '0;
        end else if (bus.flush) begin
            stage_reg <= '0;
        end else if (fire_w) begin
            stage_reg <= issue_next;
        end else if (bus.out_ready && !bus.in_valid) begin
            stage_reg <= '0;
        end else begin
            if (snoop_a_hit_w) stage_reg.data_a <= snoop_a_val_w;
            if (snoop_b_hit_w) begin
                stage_reg.store_data <= snoop_b_val_w;
                if (!stage_reg.use_imm) stage_reg.data_b <= snoop_b_val_w;
            end
        end
    end

    assign bus.out_valid      = stage_reg.valid;
    assign bus.out_data_a     = stage_reg.data_a;
    assign bus.out_data_b     = stage_reg.data_b;
    assign bus.out_store_data = stage_reg.store_data;
    assign bus.out_pc         = stage_reg.pc;
    assign bus.out_pc_plus    = stage_reg.pc_plus;
    assign bus.out_pred_pc    = stage_reg.pred_pc;
    assign bus.out_pred_taken = stage_reg.pred_taken;
    assign bus.out_rd         = stage_reg.rd;
    assign bus.out_rd_we      = stage_reg.rd_we;
    assign bus.out_ctrl       = stage_reg.ctrl;

`ifdef DECODE_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_issued <= '0;
            perf_stall  <= '0;
            perf_flush  <= '0;
        end else begin
            if (fire_w && !bus.flush && perf_issued != '1) perf_issued <= perf_issued + 32'd1;
            if (bus.in_valid && !in_ready_w && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
            if (bus.flush && perf_flush != '1) perf_flush <= perf_flush + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed + randomized bench for decode_issue_stage against a transaction-level model
// in which a held instruction's operands always equal the current architectural register values.
module tb_decode_issue_stage;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int WBP  = 2;
    localparam int CW   = 26;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    decode_issue_if #(.XLEN(XLEN), .NREGS(32), .CTRL_W(CW), .WB_PORTS(WBP)) bus_if ();

`ifdef DECODE_ISSUE_PERF_EN
    logic [31:0] perf_issued, perf_stall, perf_flush;
`endif

    decode_issue_stage #(.XLEN(XLEN), .NREGS(32), .CTRL_W(CW), .WB_PORTS(WBP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
`ifdef DECODE_ISSUE_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc, pc_plus, pred_pc;
        logic            pred_taken;
        logic [AW-1:0]   rd;
        logic            rd_we;
        logic [XLEN-1:0] a, b, sd;
        logic [CW-1:0]   ctrl;
        logic [AW-1:0]   rs1, rs2;
        logic            use_imm;
        logic [XLEN-1:0] imm;
    } model_t;

    model_t          m;
    logic [XLEN-1:0] m_rf [32];
    logic [31:0]     m_issued, m_stall, m_flush;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural value of a register as seen this cycle, including writes in flight.
    function automatic logic [XLEN-1:0] arch_val(input logic [AW-1:0] idx);
        logic [XLEN-1:0] v;
        if (idx == '0) return '0;
        v = m_rf[idx];
        for (int p = 0; p < WBP; p++)
            if (bus_if.wb_we[p] && bus_if.wb_addr[p*AW +: AW] == idx) v = bus_if.wb_data[p*XLEN +: XLEN];
        return v;
    endfunction

    task automatic model_reset();
        m = '0;
        for (int r = 0; r < 32; r++) m_rf[r] = '0;
        m_issued = '0; m_stall = '0; m_flush = '0;
    endtask

    task automatic model_step();
        bit rdy, fire;
        rdy  = !m.valid || bus_if.out_ready;
        fire = bus_if.in_valid && rdy;
        if (fire && !bus_if.flush && m_issued != 32'hFFFFFFFF) m_issued++;
        if (bus_if.in_valid && !rdy && m_stall != 32'hFFFFFFFF) m_stall++;
        if (bus_if.flush && m_flush != 32'hFFFFFFFF) m_flush++;
        if (bus_if.flush) m = '0;
        else if (fire) begin
            m.valid = 1'b1; m.pc = bus_if.in_pc; m.pc_plus = bus_if.in_pc_plus;
            m.pred_pc = bus_if.in_pred_pc; m.pred_taken = bus_if.in_pred_taken;
            m.rd = bus_if.in_rd; m.rd_we = bus_if.in_rd_we; m.ctrl = bus_if.in_ctrl;
            m.rs1 = bus_if.in_rs1; m.rs2 = bus_if.in_rs2;
            m.use_imm = bus_if.in_use_imm; m.imm = bus_if.in_imm;
        end else if (bus_if.out_ready && !bus_if.in_valid) m = '0;
        if (m.valid) begin
            m.a  = arch_val(m.rs1);
            m.sd = arch_val(m.rs2);
            m.b  = m.use_imm ? m.imm : m.sd;
        end
        for (int p = 0; p < WBP; p++)
            if (bus_if.wb_we[p] && bus_if.wb_addr[p*AW +: AW] != '0)
                m_rf[bus_if.wb_addr[p*AW +: AW]] = bus_if.wb_data[p*XLEN +: XLEN];
    endtask

    task automatic check_all();
        chk("out_valid",      64'(bus_if.out_valid),      64'(m.valid));
        chk("out_data_a",     64'(bus_if.out_data_a),     64'(m.a));
        chk("out_data_b",     64'(bus_if.out_data_b),     64'(m.b));
        chk("out_store_data", 64'(bus_if.out_store_data), 64'(m.sd));
        chk("out_pc",         64'(bus_if.out_pc),         64'(m.pc));
        chk("out_pc_plus",    64'(bus_if.out_pc_plus),    64'(m.pc_plus));
        chk("out_pred_pc",    64'(bus_if.out_pred_pc),    64'(m.pred_pc));
        chk("out_pred_taken", 64'(bus_if.out_pred_taken), 64'(m.pred_taken));
        chk("out_rd",         64'(bus_if.out_rd),         64'(m.rd));
        chk("out_rd_we",      64'(bus_if.out_rd_we),      64'(m.rd_we));
        chk("out_ctrl",       64'(bus_if.out_ctrl),       64'(m.ctrl));
`ifdef DECODE_ISSUE_PERF_EN
        chk("perf_issued", 64'(perf_issued), 64'(m_issued));
        chk("perf_stall",  64'(perf_stall),  64'(m_stall));
        chk("perf_flush",  64'(perf_flush),  64'(m_flush));
`endif
    endtask

    // Called shortly after a posedge with inputs already set; checks in_ready, clocks, checks outputs.
    task automatic step();
        #1;
        chk("in_ready", 64'(bus_if.in_ready), 64'(!m.valid || bus_if.out_ready));
        model_step();
        @(posedge clk);
        #1;
        check_all();
        $display("cyc t=%0t in_v=%0b rdy=%0b fl=%0b out_v=%0b a=%h b=%h sd=%h ctrl=%h",
                 $time, bus_if.in_valid, bus_if.out_ready, bus_if.flush, bus_if.out_valid,
                 bus_if.out_data_a, bus_if.out_data_b, bus_if.out_store_data, bus_if.out_ctrl);
    endtask

    task automatic clr_in();
        bus_if.in_valid = 0; bus_if.in_pc = '0; bus_if.in_pc_plus = '0; bus_if.in_pred_pc = '0;
        bus_if.in_pred_taken = 0; bus_if.in_rs1 = '0; bus_if.in_rs2 = '0; bus_if.in_rd = '0;
        bus_if.in_rd_we = 0; bus_if.in_use_imm = 0; bus_if.in_imm = '0; bus_if.in_ctrl = '0;
        bus_if.flush = 0; bus_if.wb_we = '0; bus_if.wb_addr = '0; bus_if.wb_data = '0;
    endtask

    task automatic wb(input int port, input logic [AW-1:0] addr, input logic [XLEN-1:0] data);
        bus_if.wb_we[port] = 1'b1;
        bus_if.wb_addr[port*AW +: AW] = addr;
        bus_if.wb_data[port*XLEN +: XLEN] = data;
    endtask

    task automatic instr(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic use_imm,
                         input logic [XLEN-1:0] imm, input logic [CW-1:0] ctrl);
        bus_if.in_valid = 1; bus_if.in_rs1 = rs1; bus_if.in_rs2 = rs2;
        bus_if.in_use_imm = use_imm; bus_if.in_imm = imm; bus_if.in_ctrl = ctrl;
        bus_if.in_pc = $urandom; bus_if.in_pc_plus = bus_if.in_pc + 32'd4; bus_if.in_pred_pc = $urandom;
        bus_if.in_pred_taken = 1'($urandom); bus_if.in_rd = 5'($urandom); bus_if.in_rd_we = 1'($urandom);
    endtask

    initial begin
        reset = 1'b0;
        clr_in();
        bus_if.out_ready = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_in_ready", 64'(bus_if.in_ready), 64'd1);
        reset = 1'b1;

        // Bypass: write x5 and read it in the same cycle.
        wb(0, 5'd5, 32'hDEADBEEF);
        instr(5'd5, 5'd0, 0, '0, 26'h1);
        step();
        chk("bypass_a", 64'(bus_if.out_data_a), 64'h0000_0000_DEAD_BEEF);
        clr_in(); step();

        // Port conflict on x7, then a write to x0.
        wb(0, 5'd7, 32'h1); wb(1, 5'd7, 32'h2); step();
        clr_in(); wb(0, 5'd0, 32'hFFFF); step();
        clr_in(); instr(5'd7, 5'd0, 0, '0, 26'h2); step();
        chk("conflict_x7", 64'(bus_if.out_data_a), 64'h2);
        chk("x0_zero", 64'(bus_if.out_store_data), 64'h0);
        clr_in(); step();

        // Stall with WB snoop of the held rs2.
        instr(5'd0, 5'd9, 0, '0, 26'h123); step();
        bus_if.out_ready = 0;
        instr(5'd1, 5'd2, 0, '0, 26'h3FF);
        for (int c = 1; c <= 3; c++) begin
            bus_if.wb_we = '0;
            if (c == 2) wb(0, 5'd9, 32'h55);
            step();
            chk("stall_in_ready", 64'(bus_if.in_ready), 64'd0);
        end
        chk("snoop_b", 64'(bus_if.out_data_b), 64'h55);
        chk("snoop_sd", 64'(bus_if.out_store_data), 64'h55);
        chk("snoop_ctrl", 64'(bus_if.out_ctrl), 64'h123);
        clr_in(); bus_if.out_ready = 1; step();

        // Flush with a held entry and a new valid input.
        instr(5'd0, 5'd0, 0, '0, 26'h55); step();
        bus_if.out_ready = 0; instr(5'd0, 5'd0, 0, '0, 26'hAA); bus_if.flush = 1; step();
        chk("flush_valid", 64'(bus_if.out_valid), 64'd0);
        chk("flush_ctrl", 64'(bus_if.out_ctrl), 64'd0);
        clr_in(); bus_if.out_ready = 1; step();
        chk("flush_none", 64'(bus_if.out_valid), 64'd0);

        // Reset in the middle of a stall.
        instr(5'd0, 5'd0, 0, '0, 26'h77); step();
        bus_if.out_ready = 0; instr(5'd0, 5'd0, 0, '0, 26'h78); step();
        #2 reset = 1'b0;
        #1 model_reset();
        check_all();
        chk("rst_mid_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rst_mid_in_ready", 64'(bus_if.in_ready), 64'd1);
        reset = 1'b1;
        clr_in(); bus_if.out_ready = 1;
        instr(5'd5, 5'd0, 0, '0, 26'h4); step();
        chk("x5_after_reset", 64'(bus_if.out_data_a), 64'd0);
        clr_in(); step();

        // Immediate select, then 4 stall cycles and one flush.
        wb(1, 5'd3, 32'h10); step();
        clr_in(); instr(5'd0, 5'd3, 1, 32'hFFFFF800, 26'h5); step();
        chk("imm_b", 64'(bus_if.out_data_b), 64'hFFFF_F800);
        chk("imm_sd", 64'(bus_if.out_store_data), 64'h10);
        bus_if.out_ready = 0; instr(5'd1, 5'd1, 0, '0, 26'h6);
        repeat (4) step();
        clr_in(); bus_if.flush = 1; step();
        clr_in(); bus_if.out_ready = 1;
`ifdef DECODE_ISSUE_PERF_EN
        chk("perf_stall_4", 64'(perf_stall), 64'd4);
        chk("perf_flush_1", 64'(perf_flush), 64'd1);
`endif

        // Randomized traffic on a narrow register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            clr_in();
            if ($urandom_range(0, 3) != 0)
                instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom), $urandom, 26'($urandom));
            for (int p = 0; p < WBP; p++)
                if ($urandom_range(0, 1) == 1) wb(p, 5'($urandom_range(0, 7)), $urandom);
            bus_if.out_ready = ($urandom_range(0, 2) != 0);
            bus_if.flush = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
